// File: rtl/lz_normalizer_pkg.sv
// Shared definitions for the leading zero/one normalizer.
// Holds the FSM state type, count-mode encodings and width helper.
package lz_normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lz_state_e;

  localparam logic LZ_MODE_ZEROS = 1'b0;
  localparam logic LZ_MODE_ONES  = 1'b1;

  // Count must be able to represent the full width itself.
  function automatic int lz_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/lz_stage.sv
// One binary-search step: if the top 2^stage bits of work are zero,
// shift work and norm left by that amount and report the increment.
module lz_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic [DATA_WIDTH-1:0] work_i,
  input  logic [DATA_WIDTH-1:0] norm_i,
  input  logic [CNT_WIDTH-1:0]  stage_i,
  output logic [DATA_WIDTH-1:0] work_o,
  output logic [DATA_WIDTH-1:0] norm_o,
  output logic [CNT_WIDTH-1:0]  inc_o
);

  logic [CNT_WIDTH-1:0]  step;
  logic [DATA_WIDTH-1:0] top_mask;
  logic                  hit;

  always_comb begin
    step     = CNT_WIDTH'(1) << stage_i;
    top_mask = ~({DATA_WIDTH{1'b1}} >> step);
    hit      = ((work_i & top_mask) == '0);
    work_o   = hit ? (work_i << step) : work_i;
    norm_o   = hit ? (norm_i << step) : norm_i;
    inc_o    = hit ? step : '0;
  end

endmodule

// File: rtl/lz_normalizer.sv
// Iterative leading zero/one counter with normalized operand output.
// One binary-search stage per clock; fixed latency of STAGES+1.
module lz_normalizer
  import lz_normalizer_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  localparam int STAGES     = $clog2(DATA_WIDTH),
  localparam int CNT_WIDTH  = lz_cnt_width(DATA_WIDTH)
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_start,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_num,
  output logic                  out_busy,
  output logic                  out_valid,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic [DATA_WIDTH-1:0] out_norm,
  output logic                  out_zero
);

  lz_state_e             state_q;
  logic [DATA_WIDTH-1:0] work_q;
  logic [DATA_WIDTH-1:0] norm_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  stage_q;
  logic                  zflag_q;
  logic                  valid_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0] res_norm_q;
  logic                  zero_q;

  logic [DATA_WIDTH-1:0] work_in;
  logic [DATA_WIDTH-1:0] work_d;
  logic [DATA_WIDTH-1:0] norm_d;
  logic [CNT_WIDTH-1:0]  inc_d;
  logic [CNT_WIDTH-1:0]  cnt_d;

  assign work_in = (in_mode == LZ_MODE_ONES) ? ~in_num : in_num;
  assign cnt_d   = cnt_q + inc_d;

  lz_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stage (
    .work_i (work_q),
    .norm_i (norm_q),
    .stage_i(stage_q),
    .work_o (work_d),
    .norm_o (norm_d),
    .inc_o  (inc_d)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      norm_q     <= '0;
      cnt_q      <= '0;
      stage_q    <= '0;
      zflag_q    <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      res_norm_q <= '0;
      zero_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (in_start) begin
            work_q  <= work_in;
            norm_q  <= in_num;
            cnt_q   <= '0;
            stage_q <= CNT_WIDTH'(STAGES - 1);
            zflag_q <= (work_in == '0);
            state_q <= RUN;
          end
        end
        RUN: begin
          work_q <= work_d;
          norm_q <= norm_d;
          cnt_q  <= cnt_d;
          if (stage_q == '0) begin
            // An all-zero search stops one short of the full width.
            count_q    <= zflag_q ? CNT_WIDTH'(DATA_WIDTH) : cnt_d;
            res_norm_q <= zflag_q ? '0 : norm_d;
            zero_q     <= zflag_q;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end else begin
            stage_q <= stage_q - 1'b1;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_busy  = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_count = count_q;
  assign out_norm  = res_norm_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_lz_normalizer.sv
// Self-checking bench for lz_normalizer: vector table, handshake
// corner sequences and randomized operands against a bit-scan model.
module tb_lz_normalizer;

  localparam int DW     = 64;
  localparam int CW     = 7;
  localparam int STAGES = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [DW-1:0] num;
  logic          busy;
  logic          valid;
  logic [CW-1:0] count;
  logic [DW-1:0] norm;
  logic          zero;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic          m;
    logic [DW-1:0] x;
    int            c;
    logic [DW-1:0] n;
    logic          z;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  lz_normalizer #(.DATA_WIDTH(DW)) dut (
    .in_clk   (clk),
    .in_rst   (rst),
    .in_start (start),
    .in_mode  (mode),
    .in_num   (num),
    .out_busy (busy),
    .out_valid(valid),
    .out_count(count),
    .out_norm (norm),
    .out_zero (zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, " busy"},  64'(busy),  64'd0);
    chk({nm, " valid"}, 64'(valid), 64'd0);
    chk({nm, " count"}, 64'(count), 64'd0);
    chk({nm, " norm"},  norm,       64'd0);
    chk({nm, " zero"},  64'(zero),  64'd0);
  endtask

  // Scan from the MSB for the first bit that differs from the mode bit.
  task automatic ref_lz(input logic m, input logic [DW-1:0] x,
                        output int c, output logic [DW-1:0] n,
                        output logic z);
    c = 0;
    while (c < DW && x[DW-1-c] == m) c++;
    z = (c == DW);
    n = z ? '0 : (x << c);
  endtask

  // Starts in the current cycle, returns in the IDLE cycle after DONE.
  task automatic run_op(input string nm, input logic m,
                        input logic [DW-1:0] x, input int ec,
                        input logic [DW-1:0] en, input logic ez);
    start = 1'b1;
    mode  = m;
    num   = x;
    step();
    start = 1'b0;
    mode  = 1'($urandom);
    num   = {$urandom, $urandom};
    for (int c = 1; c <= STAGES + 1; c++) begin
      chk({nm, " busy"}, 64'(busy), 64'd1);
      if (c <= STAGES) begin
        chk({nm, " early valid"}, 64'(valid), 64'd0);
        step();
      end else begin
        chk({nm, " valid"}, 64'(valid), 64'd1);
        chk({nm, " count"}, 64'(count), 64'(ec));
        chk({nm, " norm"},  norm,       en);
        chk({nm, " zero"},  64'(zero),  64'(ez));
      end
    end
    step();
    chk({nm, " valid drop"}, 64'(valid), 64'd0);
    chk({nm, " busy drop"},  64'(busy),  64'd0);
    chk({nm, " count hold"}, 64'(count), 64'(ec));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int            rc;
    logic [DW-1:0] rn;
    logic          rz;
    logic          rm;
    logic [DW-1:0] rx;
    int            sh;

    tbl[0] = '{1'b0, 64'h0000_0000_0000_0001, 63, 64'h8000_0000_0000_0000, 1'b0};
    tbl[1] = '{1'b0, 64'h0000_0000_0000_0000, 64, 64'h0,                   1'b1};
    tbl[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64, 64'h0,                   1'b1};
    tbl[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_F0F0, 52, 64'h0F00_0000_0000_0000, 1'b0};
    tbl[4] = '{1'b0, 64'h8000_0000_0000_0000, 0,  64'h8000_0000_0000_0000, 1'b0};
    tbl[5] = '{1'b1, 64'h8000_0000_0000_0000, 1,  64'h0,                   1'b0};
    tbl[6] = '{1'b0, 64'h00FF_FFFF_FFFF_FFFF, 8,  64'hFFFF_FFFF_FFFF_FF00, 1'b0};
    tbl[7] = '{1'b1, 64'h0000_0000_0000_0000, 0,  64'h0,                   1'b0};

    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    num   = '0;
    step();
    step();
    rst = 1'b0;
    chk_idle_zero("reset");

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].x,
             tbl[i].c, tbl[i].n, tbl[i].z);

    // Start during RUN is ignored; next start right after DONE is taken.
    start = 1'b1;
    mode  = 1'b0;
    num   = 64'h00FF_FFFF_FFFF_FFFF;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    num   = 64'h1;
    step();
    start = 1'b0;
    chk("ignore busy", 64'(busy), 64'd1);
    step();
    step();
    step();
    chk("ignore valid", 64'(valid), 64'd1);
    chk("ignore count", 64'(count), 64'd8);
    step();
    chk("ignore no 2nd valid", 64'(valid), 64'd0);
    chk("ignore idle", 64'(busy), 64'd0);
    start = 1'b1;
    num   = 64'h1;
    step();
    start = 1'b0;
    for (int c = 9; c < 15; c++) begin
      chk($sformatf("b2b early valid c%0d", c), 64'(valid), 64'd0);
      step();
    end
    chk("b2b valid", 64'(valid), 64'd1);
    chk("b2b count", 64'(count), 64'd63);
    chk("b2b norm",  norm,       64'h8000_0000_0000_0000);
    step();

    // Reset mid-operation drops the result.
    start = 1'b1;
    mode  = 1'b0;
    num   = 64'h0000_0F00_0000_0000;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_zero("midreset");
    step();
    run_op("after reset", 1'b0, 64'h0000_0F00_0000_0000, 20,
           64'hF000_0000_0000_0000, 1'b0);

    // Reset beats start in the same cycle.
    rst   = 1'b1;
    start = 1'b1;
    num   = 64'h1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst prio busy", 64'(busy), 64'd0);
    for (int c = 0; c < STAGES + 2; c++) begin
      chk($sformatf("rst prio valid c%0d", c), 64'(valid), 64'd0);
      step();
    end

    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom_range(0, 1));
      sh = $urandom_range(0, 64);
      rx = {$urandom, $urandom};
      rx = (sh == 64) ? '0 : (rx >> sh);
      if (rm) rx = ~rx;
      ref_lz(rm, rx, rc, rn, rz);
      run_op($sformatf("rand%0d", i), rm, rx, rc, rn, rz);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
